// File: rtl/led_pwm_fader.sv
// led_pwm_fader: LED output stage driven by mode/level commands from the MCU
// register logic. Two PWM-dimmed LEDs (primary and complementary) follow one
// of four modes: OFF, ON, BLINK or BREATHE (triangle fade up to the peak level).
module led_pwm_fader #(
    parameter int PWM_W       = 8,
    parameter int STEP_DIV    = 1953,
    parameter int BLINK_STEPS = 128
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [1:0]       CmdMode,
    input  logic [PWM_W-1:0] CmdLevel,
    output logic [1:0]       Mode,
    output logic [1:0]       Led
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Counter widths stay at least one bit so a divider of 1 still elaborates.
    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int BLK_W = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_STEPS - 1);

    logic             r_ready;
    logic [1:0]       r_mode;
    logic [PWM_W-1:0] r_level;
    logic [PWM_W-1:0] r_bright;
    logic             r_dir;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PRE_W-1:0] r_presc;
    logic [BLK_W-1:0] r_blink_cnt;
    logic [1:0]       r_led;

    logic             w_accept;
    logic             w_strobe;
    logic [PWM_W-1:0] w_duty0;
    logic [PWM_W-1:0] w_duty1;

    assign w_accept = CmdValid && r_ready;
    assign w_strobe = (r_presc == PRE_LAST);

    // Complementary channel shows the headroom L-b; b never exceeds L so it cannot wrap.
    assign w_duty0 = (r_mode == MODE_OFF) ? '0 : r_bright;
    assign w_duty1 = (r_mode == MODE_OFF) ? '0 : (r_level - r_bright);

    assign CmdReady = r_ready;
    assign Mode     = r_mode;
    assign Led      = r_led;

    // Ready drops for exactly one cycle after each accepted command.
    // NOTE: reset is synchronous here (sampled only at the clock edge), and every
    // register below uses non-blocking assignment so all state updates see the
    // pre-edge values of each other, as real flops do.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= !w_accept;
        end
    end

    // Free-running PWM counter; commands never disturb it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // Step prescaler: restarts on a new command, wraps after the strobe cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_presc <= '0;
        end else if (w_accept || w_strobe) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Mode/level capture and per-strobe brightness update for each mode.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mode      <= MODE_OFF;
            r_level     <= '0;
            r_bright    <= '0;
            r_dir       <= DIR_UP;
            r_blink_cnt <= '0;
        end else if (w_accept) begin
            r_mode      <= CmdMode;
            r_level     <= CmdLevel;
            r_bright    <= (CmdMode == MODE_ON) ? CmdLevel : '0;
            r_dir       <= DIR_UP;
            r_blink_cnt <= '0;
        end else if (w_strobe) begin
            case (r_mode)
                MODE_OFF: begin
                    r_bright <= '0;
                end
                MODE_ON: begin
                    r_bright <= r_level;
                end
                MODE_BLINK: begin
                    if (r_blink_cnt == BLK_LAST) begin
                        r_blink_cnt <= '0;
                        r_bright    <= (r_bright == '0) ? r_level : '0;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
                    end
                end
                default: begin
                    // Triangle fade bounded by [0, L]; turning points reverse direction.
                    if (r_level == '0) begin
                        r_bright <= '0;
                    end else if (r_dir == DIR_UP) begin
                        if (r_bright < r_level) begin
                            r_bright <= r_bright + PWM_W'(1);
                        end else begin
                            r_dir    <= DIR_DOWN;
                            r_bright <= r_bright - PWM_W'(1);
                        end
                    end else begin
                        if (r_bright > '0) begin
                            r_bright <= r_bright - PWM_W'(1);
                        end else begin
                            r_dir    <= DIR_UP;
                            r_bright <= r_bright + PWM_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Registered PWM compare drives the pins one cycle after b/pwm_cnt.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_led <= 2'b00;
        end else begin
            r_led <= {(r_pwm_cnt < w_duty1), (r_pwm_cnt < w_duty0)};
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed stimulus for led_pwm_fader with a per-cycle
// behavioural model (brightness as a closed-form function of strobes since the
// last command) plus hand-computed literal expectations.
module tb_led_pwm_fader;

    localparam int PWM_W       = 4;
    localparam int STEP_DIV    = 2;
    localparam int BLINK_STEPS = 3;
    localparam int PWM_PERIOD  = 1 << PWM_W;

    logic             Clk;
    logic             Rst;
    logic             CmdValid;
    logic             CmdReady;
    logic [1:0]       CmdMode;
    logic [PWM_W-1:0] CmdLevel;
    logic [1:0]       Mode;
    logic [1:0]       Led;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, advanced once per rising edge.
    bit         m_valid = 0;
    int         m_mode;
    int         m_level;
    int         m_ready;
    int         m_edges;
    int         m_accept_edge;
    logic [1:0] exp_led;

    led_pwm_fader #(
        .PWM_W      (PWM_W),
        .STEP_DIV   (STEP_DIV),
        .BLINK_STEPS(BLINK_STEPS)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .CmdValid(CmdValid),
        .CmdReady(CmdReady),
        .CmdMode (CmdMode),
        .CmdLevel(CmdLevel),
        .Mode    (Mode),
        .Led     (Led)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Brightness after n strobes of the given mode with peak level lvl.
    function automatic int model_b(input int mode, input int lvl, input int n);
        int p;
        case (mode)
            0: return 0;
            1: return lvl;
            2: return ((n / BLINK_STEPS) % 2 == 1) ? lvl : 0;
            default: begin
                if (lvl == 0) return 0;
                p = n % (2 * lvl);
                return (p <= lvl) ? p : (2 * lvl - p);
            end
        endcase
    endfunction

    // Model: advance the expected state across each rising edge.
    initial begin
        int b_pre, d0, d1, pwm;
        bit accept;
        forever begin
            @(posedge Clk);
            if (Rst) begin
                m_mode        = 0;
                m_level       = 0;
                m_ready       = 0;
                m_edges       = 0;
                m_accept_edge = 0;
                exp_led       = 2'b00;
            end else begin
                b_pre   = model_b(m_mode, m_level, (m_edges - m_accept_edge) / STEP_DIV);
                d0      = (m_mode == 0) ? 0 : b_pre;
                d1      = (m_mode == 0) ? 0 : (m_level - b_pre);
                pwm     = m_edges % PWM_PERIOD;
                exp_led = {(pwm < d1), (pwm < d0)};
                accept  = CmdValid && (m_ready == 1);
                m_edges++;
                if (accept) begin
                    m_mode        = int'(CmdMode);
                    m_level       = int'(CmdLevel);
                    m_accept_edge = m_edges;
                    m_ready       = 0;
                end else begin
                    m_ready = 1;
                end
            end
            m_valid = 1;
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (m_valid) begin
                check("cyc_led", int'(Led), int'(exp_led));
                check("cyc_mode", int'(Mode), m_mode);
                check("cyc_ready", int'(CmdReady), m_ready);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic send_cmd(input logic [1:0] md, input logic [PWM_W-1:0] lv);
        logic rdy;
        bit   done;
        done     = 0;
        CmdValid = 1'b1;
        CmdMode  = md;
        CmdLevel = lv;
        for (int i = 0; i < 8 && !done; i++) begin
            rdy = CmdReady;
            step();
            if (rdy) done = 1;
        end
        CmdValid = 1'b0;
        check("cmd_accepted", int'(done), 1);
    endtask

    task automatic count_high(input int cycles, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            c0 += int'(Led[0]);
            c1 += int'(Led[1]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0, c1, acc;
        logic rdy;

        Rst      = 1'b1;
        CmdValid = 1'b0;
        CmdMode  = 2'd0;
        CmdLevel = '0;

        // 1. Reset held for three edges, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_led", int'(Led), 0);
            check("rst_mode", int'(Mode), 0);
            check("rst_ready", int'(CmdReady), 0);
        end
        Rst = 1'b0;
        step();
        check("ready_after_rst", int'(CmdReady), 1);

        // 2. ON at full scale: 15 of 16 high on Led[0], Led[1] dark.
        send_cmd(2'd1, 4'd15);
        check("on_ready_low", int'(CmdReady), 0);
        step();
        check("on_ready_back", int'(CmdReady), 1);
        count_high(16, c0, c1);
        check("on_led0_duty", c0, 15);
        check("on_led1_duty", c1, 0);
        check("on_mode", int'(Mode), 1);

        // 3. BREATHE L=3: triangle fade, tracked cycle by cycle by the model.
        send_cmd(2'd3, 4'd3);
        check("breathe_mode", int'(Mode), 3);
        count_high(24, c0, c1);

        // 4. BLINK L=8: duties are always {8,0} or {0,8}, so over 48 cycles
        //    Led[0]+Led[1] is high exactly when pwm<8: 24 cycles.
        send_cmd(2'd2, 4'd8);
        check("blink_mode", int'(Mode), 2);
        count_high(48, c0, c1);
        check("blink_total_high", c0 + c1, 24);

        // 5. CmdValid held three edges: accept, ignored, accept again.
        CmdValid = 1'b1;
        CmdMode  = 2'd0;
        CmdLevel = 4'd15;
        acc = 0;
        rdy = CmdReady;
        step();
        acc += int'(rdy);
        rdy = CmdReady;
        step();
        acc += int'(rdy);
        check("off_led_2nd_edge", int'(Led), 0);
        rdy = CmdReady;
        step();
        acc += int'(rdy);
        CmdValid = 1'b0;
        check("held_valid_accepts", acc, 2);
        count_high(16, c0, c1);
        check("off_led0_dark", c0, 0);
        check("off_led1_dark", c1, 0);

        // 6. Reset in the middle of a fade, then BREATHE with L=0.
        send_cmd(2'd3, 4'd3);
        for (int i = 0; i < 4; i++) step();
        Rst = 1'b1;
        step();
        check("midrst_led", int'(Led), 0);
        check("midrst_mode", int'(Mode), 0);
        check("midrst_ready", int'(CmdReady), 0);
        Rst = 1'b0;
        step();
        send_cmd(2'd3, 4'd0);
        count_high(40, c0, c1);
        check("breathe0_led0", c0, 0);
        check("breathe0_led1", c1, 0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
